fflags_rob_idx_queue_ctrl: RTL and testbench
============================================

// Module: fflags_rob_idx_queue_ctrl
// PURPOSE
//  Pointer/occupancy controller and dequeue stage for the FP fflags rob_idx queue.
//  Owns the external DEPTH x WIDTH 1R1W RAM:
//   - drives its write port from an enq valid/ready interface
//   - drives its read port to drain entries in FIFO order into a registered deq output stage
//  Sits between the FP pipe writeback (enq) and ROB fflags commit (deq).
//  The RAM instance is in the parent; both RAM clocks are tied to `clock` there.
// PARAMETERS
//  DEPTH   7  RAM entries; need not be a power of two
//  WIDTH   7  bits per entry (rob_idx)
//  ADDR_W  3  RAM address width, >= clog2(DEPTH)
//  CNT_W   4  occupancy width, >= clog2(DEPTH+2)
// PORTS
//  clock         in   1       single clock; all state on posedge
//  reset         in   1       asynchronous, active-high
//  io_flush      in   1       synchronous queue clear
//  io_enq_valid  in   1       producer has entry
//  io_enq_ready  out  1       queue can accept
//  io_enq_bits   in   WIDTH   entry data
//  io_deq_valid  out  1       output register holds entry
//  io_deq_ready  in   1       consumer takes entry
//  io_deq_bits   out  WIDTH   output register data
//  io_count      out  CNT_W   RAM entries + io_deq_valid
//  ram_W0_addr   out  ADDR_W  = tail pointer
//  ram_W0_en     out  1       = enq_fire
//  ram_W0_data   out  WIDTH   = io_enq_bits
//  ram_R0_addr   out  ADDR_W  = head pointer
//  ram_R0_en     out  1       = rd_fire
//  ram_R0_data   in   WIDTH   combinational RAM read data; X when ram_R0_en=0
// BEHAVIOUR
//  State: head, tail (0..DEPTH-1), cnt (RAM entries, 0..DEPTH), deq_valid_q, deq_bits_q.
//  Reset (async): head=tail=cnt=0, deq_valid_q=0, deq_bits_q=0.
//   Hence io_enq_ready=1, ram_W0_en=0, ram_R0_en=0, io_count=0.
//  Handshake signals:
//   - enq_ready = (cnt != DEPTH) && !io_flush; enq_fire = io_enq_valid && enq_ready
//   - rd_fire = (cnt != 0) && (!deq_valid_q || io_deq_ready) && !io_flush
//  On rd_fire:
//   - deq_bits_q <= ram_R0_data; deq_valid_q <= 1
//   - head <= head+1, wrapping DEPTH-1 -> 0
//  Else, if io_deq_valid && io_deq_ready: deq_valid_q <= 0; deq_bits_q holds.
//  On enq_fire: tail <= tail+1, wrapping DEPTH-1 -> 0.
//  cnt <= cnt + enq_fire - rd_fire.
//   - Simultaneous enq/read leaves cnt unchanged.
//   - Never over- or underflows.
//  No write->read bypass:
//   - An entry written at edge t is first read in cycle t+1.
//   - It is visible on io_deq_* in cycle t+2, with an empty queue and io_deq_ready=1.
//   - Enq-to-deq latency is 2 cycles.
//  Throughput: one entry/cycle sustained with io_deq_ready=1.
//  Total capacity is DEPTH+1 (RAM plus output register).
//  io_flush (priority over all else):
//   - next edge: head=tail=cnt=0, deq_valid_q=0
//   - enq and read are suppressed in the flush cycle; a deq handshake in that cycle is void
//  ram_R0_data is sampled only when ram_R0_en=1; X on it otherwise must not propagate.
//  io_deq_bits is stable while io_deq_valid && !io_deq_ready.
//  Async reset mid-stream clears all state immediately, independent of clock.
// TESTING
//  1. Reset, deq_ready=0, enq 0x01..0x09 back-to-back -> 8 accepted, enq_ready=0 after 8th,
//     io_count=8, deq_valid=1 with bits 0x01 from cycle 2.
//  2. From full, deq_ready=1 -> drains 0x01..0x08 one per cycle, then deq_valid=0,
//     io_count=0, enq_ready=1.
//  3. deq_ready=1, stream 20 entries 0x00..0x13 -> exact order, 1/cycle after 2-cycle fill,
//     head/tail wrap 6->0 twice.
//  4. 5 entries queued, flush with enq_valid=1 -> next cycle deq_valid=0, io_count=0,
//     W0_en=0 in flush cycle, next enq 0x2A appears 2 cycles later.
//  5. Assert reset between edges mid-stream -> deq_valid, ram_W0_en, ram_R0_en low immediately;
//     queue empty after release.
//  6. Random enq_valid/deq_ready and occasional flush, 10k cycles vs model queue ->
//     order, io_count and capacity always match; no X on io_deq_bits when valid.

Source files
------------

// File: rtl/fflags_rob_idx_queue_ctrl.sv
`timescale 1ns/1ps
// fflags_rob_idx_queue_ctrl
// Pointer/occupancy controller for the FP fflags rob_idx queue. It drives the
// write port of an external DEPTH x WIDTH 1R1W RAM from the enq handshake, and
// drains the RAM in FIFO order into a registered deq output stage.
// Ports:
//   clock, reset       single clock, asynchronous active-high reset
//   io_flush           synchronous clear; takes priority over enq, read and deq
//   io_enq_*           producer valid/ready/bits (FP pipe writeback)
//   io_deq_*           consumer valid/ready/bits (ROB fflags commit)
//   io_count           RAM entries plus the output register
//   ram_W0_*           RAM write port (addr = tail, en = enq fire)
//   ram_R0_*           RAM read port (addr = head, en = read fire, comb data)
module fflags_rob_idx_queue_ctrl #(
  parameter int unsigned DEPTH  = 7,
  parameter int unsigned WIDTH  = 7,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_flush,
  input  logic              io_enq_valid,
  output logic              io_enq_ready,
  input  logic [WIDTH-1:0]  io_enq_bits,
  output logic              io_deq_valid,
  input  logic              io_deq_ready,
  output logic [WIDTH-1:0]  io_deq_bits,
  output logic [CNT_W-1:0]  io_count,
  output logic [ADDR_W-1:0] ram_W0_addr,
  output logic              ram_W0_en,
  output logic [WIDTH-1:0]  ram_W0_data,
  output logic [ADDR_W-1:0] ram_R0_addr,
  output logic              ram_R0_en,
  input  logic [WIDTH-1:0]  ram_R0_data
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] head_q;
  logic [ADDR_W-1:0] tail_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              deq_valid_q;
  logic [WIDTH-1:0]  deq_bits_q;

  logic enq_ready;
  logic enq_fire;
  logic rd_fire;

  // Handshakes; a flush cycle suppresses both the write and the read.
  always_comb begin
    enq_ready = (cnt_q != FULL_CNT) && !io_flush;
    enq_fire  = io_enq_valid && enq_ready;
    rd_fire   = (cnt_q != '0) && (!deq_valid_q || io_deq_ready) && !io_flush;
  end

  // Port mapping onto the RAM and the consumer.
  always_comb begin
    io_enq_ready = enq_ready;
    io_deq_valid = deq_valid_q;
    io_deq_bits  = deq_bits_q;
    io_count     = cnt_q + CNT_W'(deq_valid_q);
    ram_W0_addr  = tail_q;
    ram_W0_en    = enq_fire;
    ram_W0_data  = io_enq_bits;
    ram_R0_addr  = head_q;
    ram_R0_en    = rd_fire;
  end

  // Pointers and RAM occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (io_flush) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (rd_fire) begin
        head_q <= (head_q == LAST_IDX) ? '0 : head_q + ADDR_W'(1);
      end
      if (enq_fire) begin
        tail_q <= (tail_q == LAST_IDX) ? '0 : tail_q + ADDR_W'(1);
      end
      case ({enq_fire, rd_fire})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Output register; RAM data is only captured on a read so X never leaks in.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deq_valid_q <= 1'b0;
      deq_bits_q  <= '0;
    end else if (io_flush) begin
      deq_valid_q <= 1'b0;
    end else if (rd_fire) begin
      deq_valid_q <= 1'b1;
      deq_bits_q  <= ram_R0_data;
    end else if (deq_valid_q && io_deq_ready) begin
      deq_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fflags_rob_idx_queue_ctrl.sv
`timescale 1ns/1ps
// Directed and randomized checks for fflags_rob_idx_queue_ctrl with a
// behavioural 7x7 RAM attached to its read/write ports.
module tb_fflags_rob_idx_queue_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       io_flush;
  logic       io_enq_valid;
  logic       io_enq_ready;
  logic [6:0] io_enq_bits;
  logic       io_deq_valid;
  logic       io_deq_ready;
  logic [6:0] io_deq_bits;
  logic [3:0] io_count;
  logic [2:0] ram_W0_addr;
  logic       ram_W0_en;
  logic [6:0] ram_W0_data;
  logic [2:0] ram_R0_addr;
  logic       ram_R0_en;
  logic [6:0] ram_R0_data;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [6:0] mem [7];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_W0_en) mem[ram_W0_addr] <= ram_W0_data;
  end
  assign ram_R0_data = ram_R0_en ? mem[ram_R0_addr] : 7'bx;

  fflags_rob_idx_queue_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .io_flush     (io_flush),
    .io_enq_valid (io_enq_valid),
    .io_enq_ready (io_enq_ready),
    .io_enq_bits  (io_enq_bits),
    .io_deq_valid (io_deq_valid),
    .io_deq_ready (io_deq_ready),
    .io_deq_bits  (io_deq_bits),
    .io_count     (io_count),
    .ram_W0_addr  (ram_W0_addr),
    .ram_W0_en    (ram_W0_en),
    .ram_W0_data  (ram_W0_data),
    .ram_R0_addr  (ram_R0_addr),
    .ram_R0_en    (ram_R0_en),
    .ram_R0_data  (ram_R0_data)
  );

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; io_flush = 1'b0; io_enq_valid = 1'b0; io_enq_bits = '0; io_deq_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    total_cnt++; if (io_enq_ready !== 1'b1) $display("FAIL rst_enq_ready got %b exp 1", io_enq_ready); else pass_cnt++;
    total_cnt++; if (io_deq_valid !== 1'b0) $display("FAIL rst_deq_valid got %b exp 0", io_deq_valid); else pass_cnt++;
    total_cnt++; if (io_count !== 4'd0) $display("FAIL rst_count got %0d exp 0", io_count); else pass_cnt++;
    total_cnt++; if (ram_W0_en !== 1'b0 || ram_R0_en !== 1'b0) $display("FAIL rst_ram_en got w%b r%b exp w0 r0", ram_W0_en, ram_R0_en); else pass_cnt++;
    total_cnt++; if (io_deq_bits !== 7'h00) $display("FAIL rst_deq_bits got %h exp 00", io_deq_bits); else pass_cnt++;
  endtask

  // Fill with deq blocked: 8 of 9 accepted, head entry reaches the output in cycle 2.
  task automatic test_fill();
    for (int k = 0; k < 9; k++) begin
      next_cycle();
      io_deq_ready = 1'b0; io_enq_valid = 1'b1; io_enq_bits = 7'(k + 1);
      #1;
      total_cnt++; if (io_enq_ready !== ((k < 8) ? 1'b1 : 1'b0)) $display("FAIL fill_enq_ready k=%0d got %b exp %b", k, io_enq_ready, (k < 8)); else pass_cnt++;
      if (k == 2) begin
        total_cnt++; if (io_deq_valid !== 1'b1 || io_deq_bits !== 7'h01) $display("FAIL fill_first_deq got v%b %h exp v1 01", io_deq_valid, io_deq_bits); else pass_cnt++;
      end
    end
    next_cycle();
    io_enq_valid = 1'b0;
    #1;
    total_cnt++; if (io_count !== 4'd8) $display("FAIL fill_count got %0d exp 8", io_count); else pass_cnt++;
    total_cnt++; if (io_enq_ready !== 1'b0) $display("FAIL full_enq_ready got %b exp 0", io_enq_ready); else pass_cnt++;
    total_cnt++; if (io_deq_valid !== 1'b1 || io_deq_bits !== 7'h01) $display("FAIL full_deq got v%b %h exp v1 01", io_deq_valid, io_deq_bits); else pass_cnt++;
  endtask

  // Drain from full at one entry per cycle.
  task automatic test_drain();
    for (int j = 0; j < 9; j++) begin
      next_cycle();
      io_deq_ready = 1'b1;
      #1;
      if (j < 8) begin
        total_cnt++; if (io_deq_valid !== 1'b1 || io_deq_bits !== 7'(j + 1)) $display("FAIL drain_j%0d got v%b %h exp v1 %h", j, io_deq_valid, io_deq_bits, 7'(j + 1)); else pass_cnt++;
      end else begin
        total_cnt++; if (io_deq_valid !== 1'b0) $display("FAIL drain_empty_valid got %b exp 0", io_deq_valid); else pass_cnt++;
        total_cnt++; if (io_count !== 4'd0) $display("FAIL drain_empty_count got %0d exp 0", io_count); else pass_cnt++;
        total_cnt++; if (io_enq_ready !== 1'b1) $display("FAIL drain_enq_ready got %b exp 1", io_enq_ready); else pass_cnt++;
      end
    end
  endtask

  // 20-entry stream from reset: pointers wrap 6->0 twice, 2-cycle latency.
  task automatic test_back_to_back();
    apply_reset();
    for (int c = 0; c < 23; c++) begin
      next_cycle();
      io_deq_ready = 1'b1; io_enq_valid = (c < 20); io_enq_bits = 7'(c);
      #1;
      if (c < 20) begin
        total_cnt++; if (ram_W0_en !== 1'b1 || ram_W0_addr !== 3'(c % 7)) $display("FAIL b2b_wr c=%0d got en%b a%0d exp en1 a%0d", c, ram_W0_en, ram_W0_addr, c % 7); else pass_cnt++;
      end
      if (c >= 1 && c <= 20) begin
        total_cnt++; if (ram_R0_en !== 1'b1 || ram_R0_addr !== 3'((c - 1) % 7)) $display("FAIL b2b_rd c=%0d got en%b a%0d exp en1 a%0d", c, ram_R0_en, ram_R0_addr, (c - 1) % 7); else pass_cnt++;
      end
      if (c >= 2 && c <= 21) begin
        total_cnt++; if (io_deq_valid !== 1'b1 || io_deq_bits !== 7'(c - 2)) $display("FAIL b2b_deq c=%0d got v%b %h exp v1 %h", c, io_deq_valid, io_deq_bits, 7'(c - 2)); else pass_cnt++;
      end
      if (c >= 2 && c <= 19) begin
        total_cnt++; if (io_count !== 4'd2) $display("FAIL b2b_count c=%0d got %0d exp 2", c, io_count); else pass_cnt++;
      end
      if (c == 22) begin
        total_cnt++; if (io_deq_valid !== 1'b0 || io_count !== 4'd0) $display("FAIL b2b_end got v%b cnt%0d exp v0 cnt0", io_deq_valid, io_count); else pass_cnt++;
      end
    end
  endtask

  // Flush with 5 queued and enq_valid high, then a fresh entry.
  task automatic test_flush();
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      io_deq_ready = 1'b0; io_enq_valid = 1'b1; io_enq_bits = 7'(8'h10 + c);
      #1;
    end
    next_cycle();
    io_flush = 1'b1; io_enq_valid = 1'b1; io_enq_bits = 7'h55;
    #1;
    total_cnt++; if (io_count !== 4'd5) $display("FAIL flush_pre_count got %0d exp 5", io_count); else pass_cnt++;
    total_cnt++; if (ram_W0_en !== 1'b0 || ram_R0_en !== 1'b0) $display("FAIL flush_ram_en got w%b r%b exp w0 r0", ram_W0_en, ram_R0_en); else pass_cnt++;
    total_cnt++; if (io_enq_ready !== 1'b0) $display("FAIL flush_enq_ready got %b exp 0", io_enq_ready); else pass_cnt++;
    next_cycle();
    io_flush = 1'b0; io_enq_valid = 1'b1; io_enq_bits = 7'h2A;
    #1;
    total_cnt++; if (io_deq_valid !== 1'b0 || io_count !== 4'd0) $display("FAIL flush_post got v%b cnt%0d exp v0 cnt0", io_deq_valid, io_count); else pass_cnt++;
    total_cnt++; if (ram_W0_en !== 1'b1 || ram_W0_addr !== 3'd0) $display("FAIL flush_wr got en%b a%0d exp en1 a0", ram_W0_en, ram_W0_addr); else pass_cnt++;
    next_cycle();
    io_enq_valid = 1'b0; io_deq_ready = 1'b1;
    #1;
    total_cnt++; if (io_deq_valid !== 1'b0) $display("FAIL flush_lat1 got v%b exp v0", io_deq_valid); else pass_cnt++;
    next_cycle();
    #1;
    total_cnt++; if (io_deq_valid !== 1'b1 || io_deq_bits !== 7'h2A) $display("FAIL flush_lat2 got v%b %h exp v1 2a", io_deq_valid, io_deq_bits); else pass_cnt++;
    next_cycle();
    #1;
    total_cnt++; if (io_deq_valid !== 1'b0) $display("FAIL flush_drained got v%b exp v0", io_deq_valid); else pass_cnt++;
  endtask

  // Asynchronous reset between edges while streaming.
  task automatic test_async_reset();
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      io_deq_ready = 1'b1; io_enq_valid = 1'b1; io_enq_bits = 7'(8'h40 + c);
      #1;
    end
    total_cnt++; if (io_deq_valid !== 1'b1 || io_deq_bits !== 7'h41) $display("FAIL arst_pre got v%b %h exp v1 41", io_deq_valid, io_deq_bits); else pass_cnt++;
    #1;
    reset = 1'b1; io_enq_valid = 1'b0;
    #1;
    total_cnt++; if (io_deq_valid !== 1'b0) $display("FAIL arst_deq_valid got %b exp 0", io_deq_valid); else pass_cnt++;
    total_cnt++; if (ram_W0_en !== 1'b0 || ram_R0_en !== 1'b0) $display("FAIL arst_ram_en got w%b r%b exp w0 r0", ram_W0_en, ram_R0_en); else pass_cnt++;
    total_cnt++; if (io_count !== 4'd0) $display("FAIL arst_count got %0d exp 0", io_count); else pass_cnt++;
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    total_cnt++; if (io_deq_valid !== 1'b0 || io_count !== 4'd0 || io_enq_ready !== 1'b1) $display("FAIL arst_post got v%b cnt%0d rdy%b exp v0 cnt0 rdy1", io_deq_valid, io_count, io_enq_ready); else pass_cnt++;
    next_cycle();
    io_enq_valid = 1'b1; io_enq_bits = 7'h33;
    #1;
    next_cycle();
    io_enq_valid = 1'b0;
    #1;
    total_cnt++; if (io_deq_valid !== 1'b0) $display("FAIL arst_lat1 got v%b exp v0", io_deq_valid); else pass_cnt++;
    next_cycle();
    #1;
    total_cnt++; if (io_deq_valid !== 1'b1 || io_deq_bits !== 7'h33) $display("FAIL arst_lat2 got v%b %h exp v1 33", io_deq_valid, io_deq_bits); else pass_cnt++;
  endtask

  // Random traffic against a queue model of RAM contents plus output register.
  task automatic test_random();
    logic [6:0] rq [$];
    logic       ov;
    logic [6:0] ob;
    logic       rd, en, exp_rdy;
    apply_reset();
    ov = 1'b0; ob = '0;
    for (int c = 0; c < 10000; c++) begin
      next_cycle();
      io_flush     = ($urandom_range(0, 49) == 0);
      io_enq_valid = ($urandom_range(0, 2) != 0);
      io_deq_ready = ($urandom_range(0, 2) != 0);
      io_enq_bits  = 7'($urandom);
      #1;
      exp_rdy = (rq.size() != 7) && !io_flush;
      total_cnt++; if (io_deq_valid !== ov) $display("FAIL rnd_valid c=%0d got %b exp %b", c, io_deq_valid, ov); else pass_cnt++;
      if (ov) begin
        total_cnt++; if (io_deq_bits !== ob) $display("FAIL rnd_bits c=%0d got %h exp %h", c, io_deq_bits, ob); else pass_cnt++;
      end
      total_cnt++; if (io_count !== 4'(rq.size() + int'(ov))) $display("FAIL rnd_count c=%0d got %0d exp %0d", c, io_count, rq.size() + int'(ov)); else pass_cnt++;
      total_cnt++; if (io_enq_ready !== exp_rdy) $display("FAIL rnd_enq_ready c=%0d got %b exp %b", c, io_enq_ready, exp_rdy); else pass_cnt++;
      if (io_flush) begin
        rq.delete();
        ov = 1'b0;
      end else begin
        rd = (rq.size() != 0) && (!ov || io_deq_ready);
        en = io_enq_valid && (rq.size() != 7);
        if (rd) begin
          ob = rq.pop_front();
          ov = 1'b1;
        end else if (ov && io_deq_ready) begin
          ov = 1'b0;
        end
        if (en) rq.push_back(io_enq_bits);
      end
    end
    next_cycle();
    io_flush = 1'b0; io_enq_valid = 1'b0; io_deq_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; io_flush = 1'b0; io_enq_valid = 1'b0; io_enq_bits = '0; io_deq_ready = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
